// File: rtl/line_cmd_pkg.sv
// Shared types and constants for the line-command Avalon-MM master.
// Holds the slave register map, the queued command layout and the FSM state encoding.
package line_cmd_pkg;

  localparam logic [2:0] ASC_ADDR_MODE   = 3'd0;
  localparam logic [2:0] ASC_ADDR_STATUS = 3'd1;
  localparam logic [2:0] ASC_ADDR_GO     = 3'd2;
  localparam logic [2:0] ASC_ADDR_START  = 3'd3;
  localparam logic [2:0] ASC_ADDR_END    = 3'd4;
  localparam logic [2:0] ASC_ADDR_COLOUR = 3'd5;

  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [2:0] colour;
  } line_cmd_t;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StWrStart,
    StWrEnd,
    StWrColour,
    StWrGo,
    StPoll,
    StPollGap
  } lcm_state_e;

  function automatic logic [31:0] pack_point(input logic [8:0] x, input logic [7:0] y);
    return {15'b0, y, x};
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous command FIFO with occupancy counter; no read-through bypass.
// DEPTH must be a power of two so the pointers wrap naturally.
module line_cmd_fifo
  import line_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = line_cmd_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  entry_t          mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: the counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/line_cmd_master.sv
// Avalon-MM master replaying queued line commands as register writes to the line-drawer
// slave, then waiting for completion by GO-write stall or by STATUS polling.
module line_cmd_master
  import line_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          POLL_MODE  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [8:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  input  logic [2:0]  cmd_colour,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [15:0] lines_done
);

  lcm_state_e  state_q, state_d;
  line_cmd_t   cmd_q, cmd_d;
  line_cmd_t   fifo_in, fifo_head;
  logic        push, pop, full, empty;
  logic        wr_ack, rd_ack, count_line;
  logic        write_d, read_d;
  logic [2:0]  addr_d;
  logic [31:0] wdata_d;
  logic        unused_readdata;

  assign unused_readdata = ^avm_readdata[31:1];

  assign fifo_in   = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour};
  assign cmd_ready = !full && (state_q != StInit);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !empty || (state_q != StIdle);
  assign wr_ack    = avm_write && !avm_waitrequest;
  assign rd_ack    = avm_read && !avm_waitrequest;

  line_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (line_cmd_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    pop        = 1'b0;
    count_line = 1'b0;
    unique case (state_q)
      StInit: begin
        if (wr_ack) state_d = StIdle;
      end
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          cmd_d   = fifo_head;
          state_d = StWrStart;
        end
      end
      StWrStart: begin
        if (wr_ack) state_d = StWrEnd;
      end
      StWrEnd: begin
        if (wr_ack) state_d = StWrColour;
      end
      StWrColour: begin
        if (wr_ack) state_d = StWrGo;
      end
      StWrGo: begin
        if (wr_ack) begin
          // In stall mode the slave held GO until the line was drawn.
          if (POLL_MODE) begin
            state_d = StPoll;
          end else begin
            count_line = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StPoll: begin
        if (rd_ack) begin
          if (avm_readdata[0]) begin
            state_d = StPollGap;
          end else begin
            count_line = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StPollGap: begin
        state_d = StPoll;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so each state's
  // request is on the bus for exactly the cycles the FSM spends in that state.
  always_comb begin
    write_d = 1'b0;
    read_d  = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      StInit: begin
        write_d = 1'b1;
        addr_d  = ASC_ADDR_MODE;
        wdata_d = {31'b0, POLL_MODE};
      end
      StWrStart: begin
        write_d = 1'b1;
        addr_d  = ASC_ADDR_START;
        wdata_d = pack_point(cmd_d.x0, cmd_d.y0);
      end
      StWrEnd: begin
        write_d = 1'b1;
        addr_d  = ASC_ADDR_END;
        wdata_d = pack_point(cmd_d.x1, cmd_d.y1);
      end
      StWrColour: begin
        write_d = 1'b1;
        addr_d  = ASC_ADDR_COLOUR;
        wdata_d = {29'b0, cmd_d.colour};
      end
      StWrGo: begin
        write_d = 1'b1;
        addr_d  = ASC_ADDR_GO;
      end
      StPoll: begin
        read_d = 1'b1;
        addr_d = ASC_ADDR_STATUS;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StInit;
      cmd_q         <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      lines_done    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      avm_write     <= write_d;
      avm_read      <= read_d;
      avm_address   <= addr_d;
      avm_writedata <= wdata_d;
      if (count_line) lines_done <= lines_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_line_cmd_master.sv
// Directed bench: one polling-mode master (a) and one stall-mode master (b), checked
// against hand-computed register writes, poll spacing, FIFO back-pressure and reset.
module tb_line_cmd_master;
  import line_cmd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_cmd_valid, a_cmd_ready, a_read, a_write, a_wait, a_busy;
  logic [8:0]  a_x0, a_x1;
  logic [7:0]  a_y0, a_y1;
  logic [2:0]  a_col, a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [15:0] a_lines;

  logic        b_reset, b_cmd_valid, b_cmd_ready, b_read, b_write, b_wait, b_busy;
  logic [8:0]  b_x0, b_x1;
  logic [7:0]  b_y0, b_y1;
  logic [2:0]  b_col, b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [15:0] b_lines;

  line_cmd_master #(.FIFO_DEPTH(4), .POLL_MODE(1'b1)) dut_a (
    .clk(clk), .reset(a_reset), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_x0(a_x0), .cmd_y0(a_y0), .cmd_x1(a_x1), .cmd_y1(a_y1), .cmd_colour(a_col),
    .avm_address(a_addr), .avm_read(a_read), .avm_write(a_write), .avm_writedata(a_wdata),
    .avm_readdata(a_rdata), .avm_waitrequest(a_wait), .busy(a_busy), .lines_done(a_lines)
  );

  line_cmd_master #(.FIFO_DEPTH(4), .POLL_MODE(1'b0)) dut_b (
    .clk(clk), .reset(b_reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_x0(b_x0), .cmd_y0(b_y0), .cmd_x1(b_x1), .cmd_y1(b_y1), .cmd_colour(b_col),
    .avm_address(b_addr), .avm_read(b_read), .avm_write(b_write), .avm_writedata(b_wdata),
    .avm_readdata(b_rdata), .avm_waitrequest(b_wait), .busy(b_busy), .lines_done(b_lines)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int overlap = 0;
  int end_cycles = 0;
  int b_reads = 0;
  logic [2:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_cyc_q[$];
  bit          status_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Bus observer and STATUS responder for master a; values here are what the next edge sees.
  always @(negedge clk) begin
    if (a_read && a_write) overlap++;
    if (b_read && b_write) overlap++;
    if (b_read) b_reads++;
    if (a_write && a_addr == 3'd4) end_cycles++;
    if (a_write && !a_wait) begin
      wr_addr_q.push_back(a_addr);
      wr_data_q.push_back(a_wdata);
    end
    if (a_read && !a_wait) begin
      rd_cyc_q.push_back(cyc);
      if (status_q.size() > 0) a_rdata = {31'b0, status_q.pop_front()};
      else a_rdata = 32'd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic push_a(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] x1,
                        input logic [7:0] y1, input logic [2:0] c);
    int n = 0;
    a_x0 = x0; a_y0 = y0; a_x1 = x1; a_y1 = y1; a_col = c;
    a_cmd_valid = 1'b1;
    while (!a_cmd_ready && n < 100) begin tick(); n++; end
    check("push_ready", a_cmd_ready, 1);
    tick();
    a_cmd_valid = 1'b0;
  endtask

  task automatic wait_wr_a(input logic [2:0] addr, input string tag);
    int n = 0;
    while (!(a_write && a_addr == addr) && n < 200) begin tick(); n++; end
    check(tag, a_write && a_addr == addr, 1);
  endtask

  task automatic wait_lines_a(input logic [15:0] exp, input string tag);
    int n = 0;
    while (a_lines != exp && n < 500) begin tick(); n++; end
    check(tag, a_lines, exp);
  endtask

  logic [31:0] exp_start [6];
  logic [31:0] starts[$];

  initial begin
    a_reset = 1'b0; a_cmd_valid = 1'b0; a_wait = 1'b0; a_rdata = '0;
    a_x0 = '0; a_y0 = '0; a_x1 = '0; a_y1 = '0; a_col = '0;
    b_reset = 1'b0; b_cmd_valid = 1'b0; b_wait = 1'b0; b_rdata = '0;
    b_x0 = '0; b_y0 = '0; b_x1 = '0; b_y1 = '0; b_col = '0;
    exp_start[0] = 32'hE07; exp_start[1] = 32'h20A; exp_start[2] = 32'h414;
    exp_start[3] = 32'h61E; exp_start[4] = 32'h828; exp_start[5] = 32'hA32;

    // 1: reset values, single MODE write after release
    repeat (3) tick();
    check("rst_write", a_write, 0);
    check("rst_read", a_read, 0);
    check("rst_addr", a_addr, 0);
    check("rst_wdata", a_wdata, 0);
    check("rst_lines", a_lines, 0);
    check("rst_ready", a_cmd_ready, 0);
    check("rst_busy", a_busy, 1);
    a_reset = 1'b1;
    b_reset = 1'b1;
    tick();
    check("init_write", a_write, 1);
    check("init_addr", a_addr, 0);
    check("init_wdata", a_wdata, 1);
    check("init_ready", a_cmd_ready, 0);
    check("init_b_write", b_write, 1);
    check("init_b_wdata", b_wdata, 0);
    tick();
    check("post_init_write", a_write, 0);
    check("post_init_ready", a_cmd_ready, 1);
    check("post_init_b_ready", b_cmd_ready, 1);
    repeat (3) tick();
    check("init_one_write", wr_addr_q.size(), 1);
    check("idle_busy", a_busy, 0);
    clear_log();

    // 2: one command, status polls 1,1,0
    status_q.push_back(1'b1);
    status_q.push_back(1'b1);
    status_q.push_back(1'b0);
    push_a(9'd10, 8'd20, 9'd300, 8'd200, 3'd5);
    wait_lines_a(16'd1, "t2_lines");
    check("t2_nwr", wr_addr_q.size(), 4);
    check("t2_a0", wr_addr_q[0], 3);
    check("t2_d0", wr_data_q[0], 32'h0280A);
    check("t2_a1", wr_addr_q[1], 4);
    check("t2_d1", wr_data_q[1], 32'h1912C);
    check("t2_a2", wr_addr_q[2], 5);
    check("t2_d2", wr_data_q[2], 32'd5);
    check("t2_a3", wr_addr_q[3], 2);
    check("t2_d3", wr_data_q[3], 32'd0);
    check("t2_nrd", rd_cyc_q.size(), 3);
    check("t2_gap1", rd_cyc_q[1] - rd_cyc_q[0], 2);
    check("t2_gap2", rd_cyc_q[2] - rd_cyc_q[1], 2);
    clear_log();

    // 3: three stall cycles on the END write
    end_cycles = 0;
    push_a(9'd1, 8'd2, 9'd3, 8'd4, 3'd6);
    wait_wr_a(3'd4, "t3_end_seen");
    a_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_write", a_write, 1);
      check("t3_hold_addr", a_addr, 4);
      check("t3_hold_data", a_wdata, 32'h803);
    end
    a_wait = 1'b0;
    tick();
    check("t3_colour_addr", a_addr, 5);
    check("t3_colour_data", a_wdata, 6);
    wait_lines_a(16'd2, "t3_lines");
    check("t3_end_cycles", end_cycles, 4);
    clear_log();

    // 5: fill the FIFO while the FSM stalls on START
    a_wait = 1'b1;
    push_a(9'd7, 8'd7, 9'd8, 8'd8, 3'd1);
    wait_wr_a(3'd3, "t5_stalled");
    for (int i = 1; i <= 4; i++) begin
      a_x0 = 9'(i * 10); a_y0 = 8'(i); a_x1 = 9'(i + 100); a_y1 = 8'(i + 50); a_col = 3'(i);
      a_cmd_valid = 1'b1;
      check("t5_ready", a_cmd_ready, 1);
      tick();
    end
    a_x0 = 9'd50; a_y0 = 8'd5; a_x1 = 9'd105; a_y1 = 8'd55; a_col = 3'd5;
    check("t5_full", a_cmd_ready, 0);
    repeat (3) tick();
    check("t5_still_full", a_cmd_ready, 0);
    a_wait = 1'b0;
    begin
      int n = 0;
      while (!a_cmd_ready && n < 100) begin tick(); n++; end
    end
    check("t5_reopen", a_cmd_ready, 1);
    check("t5_reopen_write", a_write, 1);
    check("t5_reopen_addr", a_addr, 3);
    check("t5_reopen_data", a_wdata, 32'h20A);
    tick();
    a_cmd_valid = 1'b0;
    wait_lines_a(16'd8, "t5_lines");
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] == 3'd3) starts.push_back(wr_data_q[i]);
    end
    check("t5_nstarts", starts.size(), 6);
    for (int i = 0; i < 6; i++) check("t5_order", starts[i], exp_start[i]);
    clear_log();

    // 6: asynchronous reset during a stalled COLOUR write
    push_a(9'd11, 8'd12, 9'd13, 8'd14, 3'd2);
    push_a(9'd1, 8'd1, 9'd1, 8'd1, 3'd1);
    wait_wr_a(3'd5, "t6_colour");
    a_wait = 1'b1;
    tick();
    tick();
    #2 a_reset = 1'b0;
    #1;
    check("t6_async_write", a_write, 0);
    check("t6_lines", a_lines, 0);
    check("t6_ready", a_cmd_ready, 0);
    tick();
    a_wait = 1'b0;
    a_reset = 1'b1;
    clear_log();
    tick();
    check("t6_mode_write", a_write, 1);
    check("t6_mode_addr", a_addr, 0);
    check("t6_mode_data", a_wdata, 1);
    repeat (5) tick();
    check("t6_fifo_empty_busy", a_busy, 0);
    check("t6_one_write", wr_addr_q.size(), 1);

    // 4: stall mode, GO held for 50 cycles
    b_x0 = 9'd100; b_y0 = 8'd50; b_x1 = 9'd200; b_y1 = 8'd150; b_col = 3'd3;
    b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    begin
      int n = 0;
      while (!(b_write && b_addr == 3'd2) && n < 200) begin tick(); n++; end
    end
    check("t4_go_seen", b_write && b_addr == 3'd2, 1);
    b_wait = 1'b1;
    repeat (50) tick();
    check("t4_lines_held", b_lines, 0);
    check("t4_go_held", b_write, 1);
    b_wait = 1'b0;
    tick();
    check("t4_lines_after", b_lines, 1);
    check("t4_write_after", b_write, 0);
    repeat (5) tick();
    check("t4_lines_once", b_lines, 1);
    check("t4_no_reads", b_reads, 0);
    check("t4_idle", b_busy, 0);

    check("no_rw_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
